hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the RV32I 5-stage core. It drives the stage-register enables and flushes that feed the EX-stage operand forwarding logic. It also detects load-use hazards that forwarding cannot cover, freezes the pipeline on data-memory misses, and sequences taken-branch redirects. A redirect that collides with an outstanding instruction fetch is latched and replayed once the fetch returns.

## Interface
Parameters:
- none (register width from `rv32i_reg`, 5 bits)

Ports:
- `clk` in 1: core clock
- `rst` in 1: reset; synchronous, active-low
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source
- `ex_rd` in 5: destination register of the instruction in EX
- `ex_is_load` in 1: the EX instruction is a load
- `ex_br_taken` in 1: the EX instruction redirects control flow
- `ex_br_target` in 32: redirect target
- `imem_resp` in 1: fetch data valid this cycle
- `dmem_req` in 1: the MEM stage has an access outstanding
- `dmem_resp` in 1: data memory completes this cycle
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1 each: stage register load enables
- `if_id_flush`, `id_ex_flush` out 1 each: load a bubble (nop, `load_regfile`=0) instead of data
- `pc_redirect` out 1: PC mux selects `pc_redirect_target`
- `pc_redirect_target` out 32: redirect address

## Operation
Internal signals:
- `mem_stall` = `dmem_req` & ~`dmem_resp`
- `load_use` = `ex_is_load` & (`ex_rd`≠0) & ((`uses_rs1` & `ex_rd`==`id_rs1`) | (`uses_rs2` & `ex_rd`==`id_rs2`))

Registered state:
- FSM {RUN, REDIR_WAIT}
- `redir_q` target register, 32 bits

Priority each cycle: `mem_stall` > redirect > `load_use` > fetch stall.

- **`mem_stall` (any state):** all enables 0, flushes 0, `pc_redirect` 0, state and `redir_q` hold.
- **RUN, `ex_br_taken`, `imem_resp`=1:**
  - `pc_redirect`=1, `pc_redirect_target`=`ex_br_target`.
  - All enables 1; `if_id_flush`=1, `id_ex_flush`=1.
  - Stay RUN.
- **RUN, `ex_br_taken`, `imem_resp`=0:**
  - Latch `redir_q`←`ex_br_target`.
  - `pc_en`=0; `if_id_flush`=1, `id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1, so the branch advances.
  - Go REDIR_WAIT.
- **RUN, `load_use`:**
  - `pc_en`=0, `if_id_en`=0 (hold); `id_ex_flush`=1.
  - `ex_mem_en`=`mem_wb_en`=1.
  - Exactly one bubble: next cycle the load is in MEM and no longer matches.
- **RUN, `imem_resp`=0, no other event:**
  - `pc_en`=0, `if_id_en`=0; `id_ex_flush`=1.
  - EX/MEM/WB advance.
- **RUN, normal:** all enables 1, flushes 0.
- **REDIR_WAIT, `imem_resp`=0:**
  - `pc_en`=0, `if_id_en`=0; `id_ex_flush`=1.
  - EX/MEM/WB advance.
- **REDIR_WAIT, `imem_resp`=1:**
  - The wrong-path fetch is discarded: `if_id_flush`=1.
  - `pc_redirect`=1, `pc_redirect_target`=`redir_q`, `pc_en`=1; `id_ex_flush`=1.
  - Go RUN.
- **REDIR_WAIT:** `ex_br_taken` and `load_use` are ignored; younger instructions are already flushed.
- **Flush/enable interaction:** a flush asserted with the enable low still loads the bubble. Flush overrides hold.

## Timing
- All outputs are combinational from state plus inputs, with zero-cycle response.
- State and `redir_q` update on the rising `clk` edge.
- Redirect latency when `imem_resp`=1: the new PC loads on the same edge the branch leaves EX.
- Load-use costs exactly 1 bubble.
- `mem_stall` costs N cycles for an N-cycle miss.
- Reset (`rst`=0 at a clock edge):
  - state←RUN, `redir_q`←0.
  - While `rst`=0, outputs are forced: all enables 0, `if_id_flush`=`id_ex_flush`=1, `pc_redirect`=0, `pc_redirect_target`=0.
- Reset mid-REDIR_WAIT abandons the pending redirect.
- Simultaneous `mem_stall` and `ex_br_taken`: the redirect is deferred until the first non-stalled cycle. EX holds the branch, so it is re-evaluated then.
- Simultaneous `ex_br_taken` and `load_use`: the redirect wins and the ID instruction is flushed.

## Configuration
- **`HAZARD_PERF_CNT_EN` defined:** three 32-bit wrap-around counters, reset to 0, exposed as outputs `perf_load_use`, `perf_mem_stall`, `perf_redirect` (32 bits each).
  - `perf_load_use` increments on each cycle a load-use bubble is inserted.
  - `perf_mem_stall` increments on each `mem_stall` cycle.
  - `perf_redirect` increments on each cycle `pc_redirect`=1.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 for one cycle, then the load in MEM → cycle 0: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; cycle 1: all enables 1.
- **x0 and unused source:** `ex_rd`=0 matching `id_rs1`=0, and `ex_rd`=7 with `id_rs2`=7 but `id_uses_rs2`=0 → no stall, all enables 1.
- **Memory miss:** `dmem_req`=1, `dmem_resp`=0 for 4 cycles, with `ex_br_taken`=1 throughout → 4 cycles all enables 0. Cycle 5 with `dmem_resp`=1 → `pc_redirect`=1, target=`ex_br_target`.
- **Redirect during fetch stall:** `ex_br_taken`=1, target 0x0000_0400, `imem_resp`=0 → REDIR_WAIT; 3 cycles of `imem_resp`=0 → `pc_en`=0, `id_ex_flush`=1. Then `imem_resp`=1 → `if_id_flush`=1, `pc_redirect`=1, target 0x400, back to RUN.
- **Reset mid-REDIR_WAIT:** `rst`=0 for 1 edge → state RUN, `redir_q`=0; enables 0 and flushes 1 while low. With `HAZARD_PERF_CNT_EN` defined, all counters are 0.
- **Counter wrap (`HAZARD_PERF_CNT_EN`):** preload `perf_mem_stall` to 0xFFFF_FFFF via backdoor, then 1 `mem_stall` cycle → reads 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the RV32I 5-stage core: stage enables, bubbles, branch redirects.
// Latency: outputs are combinational from state + inputs (zero-cycle); state/redir_q update on rising clk.
// Backpressure: a data-memory miss freezes every stage; a fetch stall holds PC/IF-ID and bubbles ID-EX.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_rd/ex_is_load/ex_br_taken/ex_br_target : EX-stage destination, load flag, redirect request
//   imem_resp, dmem_req, dmem_resp : memory handshakes
//   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en : stage register load enables
//   if_id_flush, id_ex_flush : load a bubble (flush wins over a low enable)
//   pc_redirect, pc_redirect_target : PC mux select and address
// Optional build macro HAZARD_PERF_CNT_EN adds perf_load_use, perf_mem_stall, perf_redirect (32-bit wrap).
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        pc_redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_redirect,
`endif
  output logic [31:0] pc_redirect_target
);

  typedef enum logic {ST_RUN, ST_REDIR_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_redir_q;
  logic [31:0] w_redir_d;
  logic        w_mem_stall;
  logic        w_load_use;

  assign w_mem_stall = dmem_req & ~dmem_resp;

  // x0 never carries a real result, so a load to x0 cannot create a hazard.
  assign w_load_use = ex_is_load & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (ex_rd == id_rs1)) |
                       (id_uses_rs2 & (ex_rd == id_rs2)));

  always_comb begin
    pc_en              = 1'b1;
    if_id_en           = 1'b1;
    id_ex_en           = 1'b1;
    ex_mem_en          = 1'b1;
    mem_wb_en          = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_flush        = 1'b0;
    pc_redirect        = 1'b0;
    pc_redirect_target = (r_state == ST_REDIR_WAIT) ? r_redir_q : ex_br_target;
    w_state_nxt        = r_state;
    w_redir_d          = r_redir_q;

    if (!rst) begin
      pc_en              = 1'b0;
      if_id_en           = 1'b0;
      id_ex_en           = 1'b0;
      ex_mem_en          = 1'b0;
      mem_wb_en          = 1'b0;
      if_id_flush        = 1'b1;
      id_ex_flush        = 1'b1;
      pc_redirect_target = 32'd0;
      w_state_nxt        = ST_RUN;
      w_redir_d          = 32'd0;
    end else if (w_mem_stall) begin
      // Full freeze; a branch sitting in EX is re-evaluated once the miss clears.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (imem_resp) begin
              pc_redirect = 1'b1;
            end else begin
              // Fetch still in flight: park the target and replay it when the fetch returns.
              pc_en       = 1'b0;
              w_redir_d   = ex_br_target;
              w_state_nxt = ST_REDIR_WAIT;
            end
          end else if (w_load_use || !imem_resp) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ST_REDIR_WAIT: begin
          // Younger instructions are already flushed, so branch and load-use are ignored here.
          id_ex_flush = 1'b1;
          if (imem_resp) begin
            if_id_flush = 1'b1;
            pc_redirect = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_RUN;
      r_redir_q <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_redir_q <= w_redir_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_load_use;
  logic [31:0] r_perf_mem_stall;
  logic [31:0] r_perf_redirect;
  logic        w_lu_bubble;

  // A bubble is only attributable to load-use when no higher-priority event owns the cycle.
  assign w_lu_bubble = ~w_mem_stall & (r_state == ST_RUN) & ~ex_br_taken & w_load_use;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_load_use  <= 32'd0;
      r_perf_mem_stall <= 32'd0;
      r_perf_redirect  <= 32'd0;
    end else begin
      if (w_lu_bubble) r_perf_load_use  <= r_perf_load_use + 32'd1;
      if (w_mem_stall) r_perf_mem_stall <= r_perf_mem_stall + 32'd1;
      if (pc_redirect) r_perf_redirect  <= r_perf_redirect + 32'd1;
    end
  end

  assign perf_load_use  = r_perf_load_use;
  assign perf_mem_stall = r_perf_mem_stall;
  assign perf_redirect  = r_perf_redirect;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vector table for the multi-cycle corner cases, then randomized
// cycles checked against a rule-level reference model (pending-redirect bookkeeping, priority rules).
// Control outputs are compared under a care mask so only behaviour the block defines is checked.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken;
  logic [31:0] ex_br_target;
  logic        imem_resp, dmem_req, dmem_resp;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, pc_redirect;
  logic [31:0] pc_redirect_target;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use, perf_mem_stall, perf_redirect;
`endif

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect),
`ifdef HAZARD_PERF_CNT_EN
    .perf_load_use(perf_load_use), .perf_mem_stall(perf_mem_stall), .perf_redirect(perf_redirect),
`endif
    .pc_redirect_target(pc_redirect_target)
  );

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  rd;
    logic        ld;
    logic        br;
    logic [31:0] tgt;
    logic        imem;
    logic        dreq;
    logic        dresp;
  } in_t;

  // ctl bit order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  typedef struct packed {
    in_t         i;
    logic [6:0]  ctl;
    logic [6:0]  care;
    logic        redir;
    logic [31:0] tgt;
  } vec_t;

  vec_t tbl [0:31];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: is a redirect waiting for the fetch to return, and where to.
  bit          pend = 1'b0;
  logic [31:0] pend_tgt = 32'd0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] c_lu = 0, c_ms = 0, c_rd = 0;
`endif

  localparam logic [6:0] ALL_EN   = 7'b1111100;
  localparam logic [6:0] ALL_ON   = 7'b1111111;
  localparam logic [6:0] FROZEN   = 7'b0000000;
  localparam logic [6:0] RST_CTL  = 7'b0000011;
  localparam logic [6:0] HOLD     = 7'b0011101;  // pc/if_id held, ID-EX bubble, back end advances
  localparam logic [6:0] HOLD_M   = 7'b1101101;
  localparam logic [6:0] PARK     = 7'b0001111;  // redirect parked: pc held, both flushed
  localparam logic [6:0] PARK_M   = 7'b1001111;
  localparam logic [6:0] REPLAY   = 7'b1000011;
  localparam logic [6:0] REPLAY_M = 7'b1000011;

  function automatic in_t mkin(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                               input logic a1, input logic a2, input logic [4:0] d,
                               input logic l, input logic b, input logic [31:0] t,
                               input logic im, input logic rq, input logic rp);
    in_t v;
    v = '{rst: r, rs1: s1, rs2: s2, u1: a1, u2: a2, rd: d, ld: l, br: b, tgt: t,
          imem: im, dreq: rq, dresp: rp};
    return v;
  endfunction

  task automatic add(input in_t v, input logic [6:0] c, input logic [6:0] m,
                     input logic r, input logic [31:0] t);
    tbl[nv] = '{i: v, ctl: c, care: m, redir: r, tgt: t};
    nv++;
  endtask

  // Expected behaviour from the priority rules: reset > miss > pending redirect > branch > load-use/fetch stall.
  function automatic void model(input in_t v, output logic [6:0] c, output logic [6:0] m,
                                output logic r, output logic [31:0] t,
                                output bit np, output logic [31:0] nt);
    bit miss, hz;
    miss = v.dreq && !v.dresp;
    hz   = v.ld && v.rd != 0 && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2));
    c = ALL_EN; m = 7'h7F; r = 1'b0; t = 32'd0; np = pend; nt = pend_tgt;
    if (!v.rst) begin
      c = RST_CTL; np = 1'b0; nt = 32'd0;
    end else if (miss) begin
      c = FROZEN;
    end else if (pend) begin
      if (v.imem) begin
        c = REPLAY; m = REPLAY_M; r = 1'b1; t = pend_tgt; np = 1'b0;
      end else begin
        c = HOLD; m = HOLD_M;
      end
    end else if (v.br) begin
      if (v.imem) begin
        c = ALL_ON; r = 1'b1; t = v.tgt;
      end else begin
        c = PARK; m = PARK_M; np = 1'b1; nt = v.tgt;
      end
    end else if (hz || !v.imem) begin
      c = HOLD; m = HOLD_M;
    end
  endfunction

  task automatic step(input in_t v, input logic [6:0] ec_i, input logic [6:0] em_i,
                      input logic er_i, input logic [31:0] et_i, input bit use_model, input string nm);
    logic [6:0] mc, mm, ec, em, act;
    logic mr, er;
    logic [31:0] mt, et;
    bit np;
    logic [31:0] nt;
    @(negedge clk);
    rst = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_br_taken = v.br; ex_br_target = v.tgt;
    imem_resp = v.imem; dmem_req = v.dreq; dmem_resp = v.dresp;
    #1;
    model(v, mc, mm, mr, mt, np, nt);
    if (use_model) begin ec = mc; em = mm; er = mr; et = mt; end
    else begin ec = ec_i; em = em_i; er = er_i; et = et_i; end
    act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    checks++;
    if ((act & em) !== (ec & em)) begin
      errors++;
      $display("FAIL %s ctl: got %b want %b (care %b)", nm, act, ec, em);
    end
    checks++;
    if (pc_redirect !== er) begin
      errors++;
      $display("FAIL %s pc_redirect: got %b want %b", nm, pc_redirect, er);
    end
    if (er || !v.rst) begin
      checks++;
      if (pc_redirect_target !== et) begin
        errors++;
        $display("FAIL %s target: got %h want %h", nm, pc_redirect_target, et);
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    if (!v.rst) begin c_lu = 0; c_ms = 0; c_rd = 0; end
    else begin
      if (!(v.dreq && !v.dresp) && !pend && !v.br &&
          v.ld && v.rd != 0 && ((v.u1 && v.rd == v.rs1) || (v.u2 && v.rd == v.rs2))) c_lu++;
      if (v.dreq && !v.dresp) c_ms++;
      if (mr) c_rd++;
    end
`endif
    pend = np; pend_tgt = nt;
  endtask

  initial begin
    in_t n, v;
    n = mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), RST_CTL, 7'h7F, 0, 0);            // reset
    add(n, ALL_EN, 7'h7F, 0, 0);                                                   // normal
    add(mkin(1, 5, 0, 1, 0, 5, 1, 0, 0, 1, 0, 0), HOLD, HOLD_M, 0, 0);             // load-use
    add(n, ALL_EN, 7'h7F, 0, 0);                                                   // load now in MEM
    add(mkin(1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0), ALL_EN, 7'h7F, 0, 0);            // rd = x0
    add(mkin(1, 3, 7, 0, 0, 7, 1, 0, 0, 1, 0, 0), ALL_EN, 7'h7F, 0, 0);            // rs2 unused
    for (int k = 0; k < 4; k++)
      add(mkin(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 1, 1, 0), FROZEN, 7'h7F, 0, 0);   // 4-cycle miss + branch
    add(mkin(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 1, 1, 1), ALL_ON, 7'h7F, 1, 32'h1234);
    add(mkin(1, 0, 0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0), PARK, PARK_M, 0, 0);       // redirect vs fetch stall
    add(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HOLD, HOLD_M, 0, 0);
    add(mkin(1, 5, 0, 1, 0, 5, 1, 1, 32'h888, 0, 0, 0), HOLD, HOLD_M, 0, 0);        // branch/load-use ignored
    add(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HOLD, HOLD_M, 0, 0);
    add(mkin(1, 0, 0, 0, 0, 0, 0, 1, 32'h999, 1, 0, 0), REPLAY, REPLAY_M, 1, 32'h400); // replay parked target
    add(n, ALL_EN, 7'h7F, 0, 0);                                                   // back in RUN
    add(mkin(1, 0, 0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0), PARK, PARK_M, 0, 0);
    add(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), RST_CTL, 7'h7F, 0, 0);           // reset mid-wait
    add(n, ALL_EN, 7'h7F, 0, 0);                                                   // pending redirect gone
    add(mkin(1, 5, 0, 1, 0, 5, 1, 1, 32'h600, 1, 0, 0), ALL_ON, 7'h7F, 1, 32'h600); // branch beats load-use
    add(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), HOLD, HOLD_M, 0, 0);             // plain fetch stall

    for (int k = 0; k < nv; k++)
      step(tbl[k].i, tbl[k].ctl, tbl[k].care, tbl[k].redir, tbl[k].tgt, 1'b0, $sformatf("vec%0d", k));

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    dut.r_perf_mem_stall = 32'hFFFF_FFFF;
    c_ms = 32'hFFFF_FFFF;
    step(mkin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), 0, 0, 0, 0, 1'b1, "wrap");
    @(negedge clk);
    checks++;
    if (perf_mem_stall !== 32'd0) begin
      errors++;
      $display("FAIL perf_wrap: got %h want 0", perf_mem_stall);
    end
`endif

    for (int k = 0; k < 400; k++) begin
      v = mkin($urandom_range(39) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
               1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(3)),
               1'($urandom_range(1)), $urandom_range(4) == 0, $urandom & 32'hFFFF_FFFC,
               $urandom_range(3) != 0, $urandom_range(3) == 0, 1'($urandom_range(1)));
      step(v, 0, 0, 0, 0, 1'b1, $sformatf("rnd%0d", k));
    end

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    checks++;
    if (perf_load_use !== c_lu || perf_mem_stall !== c_ms || perf_redirect !== c_rd) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d/%0d want %0d/%0d/%0d",
               perf_load_use, perf_mem_stall, perf_redirect, c_lu, c_ms, c_rd);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
